// File: rtl/cpu_pkg.sv
// cpu_pkg: shared width, opcode encoding and decode helpers for the exec stage.
package cpu_pkg;
  localparam int W = 8;
  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_LDI = 4'h1, OP_LD  = 4'h2, OP_ST  = 4'h3,
    OP_ADD = 4'h4, OP_SUB = 4'h5, OP_AND = 4'h6, OP_OR  = 4'h7,
    OP_JMP = 4'h8, OP_JZ  = 4'h9, OP_JC  = 4'hA, OP_HLT = 4'hF
  } op_e;
  function automatic logic is_legal(logic [3:0] op);
    return !(op inside {4'hB, 4'hC, 4'hD, 4'hE});
  endfunction
  function automatic logic reads_mem(logic [3:0] op);
    return op inside {OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR};
  endfunction
  function automatic logic writes_acc(logic [3:0] op);
    return op == OP_LDI || reads_mem(op);
  endfunction
endpackage

// File: rtl/exec_if.sv
// exec_if: stage-controller, RAM and PC connections of the exec unit.
interface exec_if #(parameter int W = cpu_pkg::W);
  logic         execa, execb;
  logic [W-1:0] ira, irb, mem_rdata;
  logic [W-1:0] mem_addr, mem_wdata, pc_in, acc;
  logic         mem_rden, mem_wren, pc_load, zf, cf, halt, err;
  modport master (
    output execa, execb, ira, irb, mem_rdata,
    input  mem_addr, mem_wdata, mem_rden, mem_wren, pc_load, pc_in, acc, zf, cf, halt, err
  );
  modport slave (
    input  execa, execb, ira, irb, mem_rdata,
    output mem_addr, mem_wdata, mem_rden, mem_wren, pc_load, pc_in, acc, zf, cf, halt, err
  );
endinterface

// File: rtl/exec_alu.sv
// exec_alu: combinational accumulator ALU; cout is carry for ADD, borrow for SUB.
module exec_alu import cpu_pkg::*; #(parameter int W = cpu_pkg::W) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   op,
  output logic [W-1:0] y,
  output logic         cout
);
  logic [W:0] sum, dif;
  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    dif  = {1'b0, a} - {1'b0, b};
    y    = op == OP_ADD ? sum[W-1:0] : op == OP_SUB ? dif[W-1:0] :
           op == OP_AND ? a & b : op == OP_OR ? a | b : b;
    cout = op == OP_ADD ? sum[W] : (op == OP_SUB) & dif[W];
  end
endmodule

// File: rtl/exec_unit.sv
// exec_unit: two-cycle accumulator execute stage (execa = address/decode, execb = writeback).
module exec_unit import cpu_pkg::*; #(parameter int W = cpu_pkg::W) (
  input logic clk,
  input logic rst,
  exec_if.slave bus
);
  logic [W-1:0] acc_q, acc_d, alu_y;
  logic [3:0]   op_q, op_d, opa;
  logic         zf_q, zf_d, cf_q, cf_d, halt_q, halt_d, err_q, err_d;
  logic         alu_c, a_v, b_v, prot, wacc, ill, rd, wr, jmp;
  exec_alu #(.W(W)) u_alu (.a(acc_q), .b(bus.mem_rdata), .op(op_q), .y(alu_y), .cout(alu_c));
  always_comb begin
    opa    = bus.ira[7:4];
    a_v    = bus.execa & ~bus.execb & ~halt_q;
    b_v    = bus.execb & ~bus.execa & ~halt_q;
    prot   = bus.execa & bus.execb & ~halt_q;
    wacc   = b_v & writes_acc(op_q);
    ill    = b_v & ~is_legal(op_q);
    op_d   = a_v ? opa : op_q;
    acc_d  = wacc ? (op_q == OP_LDI ? bus.irb : alu_y) : acc_q;
    zf_d   = wacc ? acc_d == '0 : zf_q;
    cf_d   = wacc ? alu_c : cf_q;
    halt_d = halt_q | ill | (b_v & op_q == OP_HLT);
    err_d  = err_q | ill | prot;
  end
  // outputs are forced low while reset is held, even if strobes are active
  always_comb begin
    rd  = rst & a_v & reads_mem(opa);
    wr  = rst & a_v & opa == OP_ST;
    jmp = rst & b_v & (op_q == OP_JMP | (op_q == OP_JZ & zf_q) | (op_q == OP_JC & cf_q));
  end
  assign bus.mem_rden  = rd;
  assign bus.mem_wren  = wr;
  assign bus.mem_addr  = (rd | wr) ? bus.irb : '0;
  assign bus.mem_wdata = wr ? acc_q : '0;
  assign bus.pc_load   = jmp;
  assign bus.pc_in     = jmp ? bus.irb : '0;
  assign bus.acc       = acc_q;
  assign bus.zf        = zf_q;
  assign bus.cf        = cf_q;
  assign bus.halt      = halt_q;
  assign bus.err       = err_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q  <= '0;
      op_q   <= '0;
      zf_q   <= 1'b0;
      cf_q   <= 1'b0;
      halt_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      op_q   <= op_d;
      zf_q   <= zf_d;
      cf_q   <= cf_d;
      halt_q <= halt_d;
      err_q  <= err_d;
    end
  end
endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: table-driven program plus corner sequences, scoreboarded state checks.
module tb_exec_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  exec_if bus ();
  exec_unit dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [7:0] mem [256];
  always @(posedge clk) if (bus.mem_wren) mem[bus.mem_addr] <= bus.mem_wdata;
  int tests = 0;
  int fails = 0;
  typedef struct {logic [7:0] acc; logic zf, cf, halt, err;} st_t;
  typedef struct {logic [3:0] op; logic [7:0] irb; logic setm; logic [7:0] mval;
                  logic [7:0] acc; logic zf, cf, pcl;} vec_t;
  st_t  sbq[$];
  vec_t tv[20];
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic settle();
    st_t e;
    if (sbq.size() == 0) return;
    e = sbq.pop_front();
    chk("acc", bus.acc, e.acc);
    chk("zf", bus.zf, e.zf);
    chk("cf", bus.cf, e.cf);
    chk("halt", bus.halt, e.halt);
    chk("err", bus.err, e.err);
  endtask
  task automatic phase_a(logic [3:0] op, logic [7:0] irb, logic [7:0] pacc, logic live);
    logic rd, wr;
    @(posedge clk); #1;
    settle();
    bus.execb = 1'b0; bus.execa = 1'b1; bus.ira = {op, 4'h3}; bus.irb = irb;
    rd = live && op inside {4'h2, 4'h4, 4'h5, 4'h6, 4'h7};
    wr = live && op == 4'h3;
    @(negedge clk);
    chk("mem_rden", bus.mem_rden, rd);
    chk("mem_wren", bus.mem_wren, wr);
    chk("mem_addr", bus.mem_addr, (rd | wr) ? irb : 8'h00);
    chk("mem_wdata", bus.mem_wdata, wr ? pacc : 8'h00);
  endtask
  task automatic phase_b(logic setm, logic [7:0] mval, logic pcl);
    @(posedge clk); #1;
    bus.execa = 1'b0; bus.execb = 1'b1; bus.ira = 8'hB0;
    bus.mem_rdata = setm ? mval : mem[bus.irb];
    @(negedge clk);
    chk("pc_load", bus.pc_load, pcl);
    chk("pc_in", bus.pc_in, pcl ? bus.irb : 8'h00);
  endtask
  task automatic flush();
    @(posedge clk); #1;
    settle();
    bus.execa = 1'b0; bus.execb = 1'b0;
  endtask
  task automatic do_reset();
    @(negedge clk); rst = 1'b0;
    #2 rst = 1'b1;
  endtask
  task automatic instr(logic [3:0] op, logic [7:0] irb, logic [7:0] pacc, st_t e);
    phase_a(op, irb, pacc, 1'b1);
    sbq.push_back(e);
    phase_b(1'b0, 8'h00, 1'b0);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.execa = 0; bus.execb = 0; bus.ira = 0; bus.irb = 0; bus.mem_rdata = 0;
    tv[0]  = '{4'h1, 8'h05, 0, 8'h00, 8'h05, 0, 0, 0};
    tv[1]  = '{4'h4, 8'h10, 1, 8'hFE, 8'h03, 0, 1, 0};
    tv[2]  = '{4'h5, 8'h11, 1, 8'h03, 8'h00, 1, 0, 0};
    tv[3]  = '{4'h1, 8'h5A, 0, 8'h00, 8'h5A, 0, 0, 0};
    tv[4]  = '{4'h3, 8'h20, 0, 8'h00, 8'h5A, 0, 0, 0};
    tv[5]  = '{4'h1, 8'h00, 0, 8'h00, 8'h00, 1, 0, 0};
    tv[6]  = '{4'h2, 8'h20, 0, 8'h00, 8'h5A, 0, 0, 0};
    tv[7]  = '{4'h6, 8'h12, 1, 8'h0F, 8'h0A, 0, 0, 0};
    tv[8]  = '{4'h7, 8'h13, 1, 8'hF0, 8'hFA, 0, 0, 0};
    tv[9]  = '{4'h5, 8'h14, 1, 8'hFB, 8'hFF, 0, 1, 0};
    tv[10] = '{4'h0, 8'h99, 0, 8'h00, 8'hFF, 0, 1, 0};
    tv[11] = '{4'h4, 8'h15, 1, 8'h01, 8'h00, 1, 1, 0};
    tv[12] = '{4'h6, 8'h16, 1, 8'h00, 8'h00, 1, 0, 0};
    tv[13] = '{4'h8, 8'h33, 0, 8'h00, 8'h00, 1, 0, 1};
    tv[14] = '{4'h9, 8'h40, 0, 8'h00, 8'h00, 1, 0, 1};
    tv[15] = '{4'hA, 8'h50, 0, 8'h00, 8'h00, 1, 0, 0};
    tv[16] = '{4'h1, 8'h80, 0, 8'h00, 8'h80, 0, 0, 0};
    tv[17] = '{4'h9, 8'h40, 0, 8'h00, 8'h80, 0, 0, 0};
    tv[18] = '{4'h5, 8'h17, 1, 8'h81, 8'hFF, 0, 1, 0};
    tv[19] = '{4'hA, 8'h55, 0, 8'h00, 8'hFF, 0, 1, 1};
    bus.execa = 1'b1; bus.ira = 8'h20; bus.irb = 8'h10;
    #12;
    chk("rst_acc", bus.acc, 8'h00);
    chk("rst_flags", {bus.zf, bus.cf, bus.halt, bus.err}, 4'b0000);
    chk("rst_rden", bus.mem_rden, 1'b0);
    chk("rst_addr", bus.mem_addr, 8'h00);
    chk("rst_pcl", bus.pc_load, 1'b0);
    bus.execa = 1'b0;
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      phase_a(tv[i].op, tv[i].irb, i > 0 ? tv[i-1].acc : 8'h00, 1'b1);
      sbq.push_back('{tv[i].acc, tv[i].zf, tv[i].cf, 1'b0, 1'b0});
      phase_b(tv[i].setm, tv[i].mval, tv[i].pcl);
    end
    instr(4'hF, 8'h00, 8'hFF, '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0});
    phase_a(4'h1, 8'h77, 8'hFF, 1'b0);
    sbq.push_back('{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0});
    phase_b(1'b0, 8'h00, 1'b0);
    phase_a(4'h3, 8'h21, 8'hFF, 1'b0);
    sbq.push_back('{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0});
    phase_b(1'b0, 8'h00, 1'b0);
    flush();
    do_reset();
    instr(4'h1, 8'h12, 8'h00, '{8'h12, 1'b0, 1'b0, 1'b0, 1'b0});
    instr(4'hC, 8'h00, 8'h12, '{8'h12, 1'b0, 1'b0, 1'b1, 1'b1});
    flush();
    do_reset();
    instr(4'h1, 8'h34, 8'h00, '{8'h34, 1'b0, 1'b0, 1'b0, 1'b0});
    flush();
    @(posedge clk); #1;
    bus.execa = 1'b1; bus.execb = 1'b1; bus.ira = 8'h20; bus.irb = 8'h20; bus.mem_rdata = 8'h01;
    @(negedge clk);
    chk("prot_rden", bus.mem_rden, 1'b0);
    chk("prot_addr", bus.mem_addr, 8'h00);
    @(posedge clk); #1;
    bus.execa = 1'b0; bus.execb = 1'b0;
    chk("prot_err", bus.err, 1'b1);
    chk("prot_acc", bus.acc, 8'h34);
    chk("prot_halt", bus.halt, 1'b0);
    do_reset();
    instr(4'h1, 8'h09, 8'h00, '{8'h09, 1'b0, 1'b0, 1'b0, 1'b0});
    flush();
    phase_a(4'h4, 8'h10, 8'h09, 1'b1);
    rst = 1'b0;
    #1;
    chk("mid_rst_acc", bus.acc, 8'h00);
    chk("mid_rst_rden", bus.mem_rden, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1; bus.execa = 1'b0; bus.execb = 1'b1; bus.mem_rdata = 8'hFE;
    @(posedge clk); #1;
    bus.execb = 1'b0;
    chk("mid_post_acc", bus.acc, 8'h00);
    chk("mid_post_flags", {bus.zf, bus.cf, bus.err}, 3'b000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 SHALL have parameter W, default 8, giving the data/address width.
REQ-002 SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports execa and execb, input, 1 each, one-cycle exec strobes from the stage controller.
REQ-005 SHALL have ports ira and irb, input, W each: opcode byte and operand byte (immediate or address).
REQ-006 SHALL have port mem_rdata, input, W, RAM read data, valid in the execb cycle.
REQ-007 SHALL have ports mem_addr and mem_wdata, output, W each: RAM address and write data.
REQ-008 SHALL have ports mem_rden and mem_wren, output, 1 each: RAM read and write enables.
REQ-009 SHALL have ports pc_load, output, 1, and pc_in, output, W: jump request and target to the program counter.
REQ-010 SHALL have port acc, output, W, the accumulator.
REQ-011 SHALL have ports zf and cf, output, 1 each: zero and carry/borrow flags.
REQ-012 SHALL have ports halt and err, output, 1 each: sticky halt (to the stage controller halt input) and sticky error.

Function
REQ-013 Opcode SHALL be ira[7:4]: 0 NOP, 1 LDI, 2 LD, 3 ST, 4 ADD, 5 SUB, 6 AND, 7 OR, 8 JMP, 9 JZ, A JC, F HLT; B-E illegal; ira[3:0] ignored.
REQ-014 On execa, opcode SHALL be latched into an internal op register; execb SHALL act on the latched opcode, not on live ira.
REQ-015 In the execa cycle, LD/ADD/SUB/AND/OR SHALL drive mem_addr=irb and mem_rden=1, combinationally.
REQ-016 In the execa cycle, ST SHALL drive mem_addr=irb, mem_wdata=acc and mem_wren=1; the write completes at that edge.
REQ-017 When no read or write is active, mem_rden, mem_wren, mem_addr and mem_wdata SHALL all be 0.
REQ-018 At the end of the execb cycle, acc SHALL update: LDI to irb; LD to mem_rdata; ADD/SUB/AND/OR to acc op mem_rdata, modulo 2^W.
REQ-019 ADD SHALL set cf to bit W of the W+1-bit sum; SUB SHALL set cf=1 iff acc < mem_rdata (unsigned borrow).
REQ-020 AND/OR/LD/LDI SHALL clear cf; every acc-writing opcode SHALL set zf=(new acc==0); all other opcodes SHALL leave zf and cf unchanged.
REQ-021 In the execb cycle, JMP, JZ with zf=1 and JC with cf=1 SHALL assert pc_load=1 and pc_in=irb combinationally; otherwise pc_load=0 and pc_in=0.
REQ-022 HLT SHALL set halt at the end of execb; halt SHALL stay 1 until reset, and execa/execb SHALL be ignored while halt=1.
REQ-023 An illegal opcode SHALL set both err and halt at the end of execb, leaving acc and the flags unchanged.
REQ-024 execa and execb asserted together SHALL be a protocol error: no memory access, no state update except err<=1.
REQ-025 Total latency SHALL be 2 cycles (execa then execb); back-to-back instructions SHALL need no idle cycle.

Reset
REQ-026 rst=0 SHALL immediately clear acc, zf, cf, halt, err and the op register to 0, independent of clk.
REQ-027 Reset asserted mid-instruction SHALL abort it, with no acc or flag update after release.
REQ-028 All combinational outputs SHALL be 0 while rst=0.

Structure
REQ-029 Opcode constants and W SHALL live in the shared package cpu_pkg.
REQ-030 The combinational ALU SHALL be the sub-module exec_alu: inputs a, b, op; outputs y and cout.

Verification
REQ-031 LDI irb=8'h05, then ADD with mem[8'h10]=8'hFE: acc=8'h03, cf=1, zf=0.
REQ-032 ST with acc=8'h5A, irb=8'h20: execa cycle shows mem_wren=1, mem_addr=8'h20, mem_wdata=8'h5A; a later LD 8'h20 returns acc=8'h5A.
REQ-033 SUB with acc=8'h03, mem=8'h03: acc=0, zf=1, cf=0; then JZ irb=8'h40: pc_load=1 and pc_in=8'h40 during execb; with zf=0: pc_load=0.
REQ-034 HLT: halt=1 after execb; a following execa with LDI leaves acc unchanged and mem_* stays 0.
REQ-035 Opcode 8'hC0: err=1, halt=1, acc unchanged; rst pulsed low between execa and execb of an ADD: acc=0 and no update after release.
